// File: rtl/spi_daq_pkg.sv
// Shared types and helpers for the SPI DAQ scan sequencer.
//   spi_scan_state_e : scan FSM state encoding
//   build_cmd()      : channel-select command word (bit frame_w-1 set,
//                      channel number in the bits directly below it)
package spi_daq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_SETUP,
        ST_SHIFT,
        ST_GAP,
        ST_RESULT,
        ST_FINISH
    } spi_scan_state_e;

    // Widest frame supported; callers truncate to their own FRAME_W.
    localparam int MAX_FRAME_W = 32;

    function automatic logic [MAX_FRAME_W-1:0] build_cmd(
        input logic [3:0] ch,
        input int         frame_w,
        input int         ch_w
    );
        logic [MAX_FRAME_W-1:0] cmd;
        cmd = (MAX_FRAME_W'(1) << (frame_w - 1))
            | (MAX_FRAME_W'(ch) << (frame_w - 1 - ch_w));
        return cmd;
    endfunction

endpackage

// File: rtl/spi_daq_scan_ctrl_shifter.sv
// SPI mode-0 bit engine: sck divider plus MOSI/MISO shift registers.
// A load pulse starts one frame: CLK_DIV cycles of setup with sck low and the
// command MSB on mosi, then FRAME_W bits of CLK_DIV high + CLK_DIV low.
//   clk, rst_n  : clock, async active-low reset
//   load        : start a frame with cmd (ignored bits while active are not expected)
//   cmd         : command word shifted out MSB first
//   miso        : serial input, sampled as sck is driven high
//   sck, mosi   : registered SPI outputs
//   frame_done  : high during the final low-half cycle of the frame
//   rx_word     : captured MISO word, valid once frame_done has been seen
module spi_daq_shifter #(
    parameter int FRAME_W = 16,
    parameter int CLK_DIV = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [FRAME_W-1:0] cmd,
    input  logic               miso,
    output logic               sck,
    output logic               mosi,
    output logic               frame_done,
    output logic [FRAME_W-1:0] rx_word
);

    localparam int DIV_W  = $clog2(CLK_DIV + 1);
    localparam int HALF_W = $clog2(2 * FRAME_W + 1);

    logic               active_q, active_d;
    logic [DIV_W-1:0]   div_q, div_d;
    // Remaining sck half-periods; the setup interval runs while this is 2*FRAME_W.
    logic [HALF_W-1:0]  halves_q, halves_d;
    logic               sck_q, sck_d;
    logic               mosi_q, mosi_d;
    logic [FRAME_W-1:0] tx_q, tx_d;
    logic [FRAME_W-1:0] rx_q, rx_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            div_q    <= '0;
            halves_q <= '0;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b0;
            tx_q     <= '0;
            rx_q     <= '0;
        end else begin
            active_q <= active_d;
            div_q    <= div_d;
            halves_q <= halves_d;
            sck_q    <= sck_d;
            mosi_q   <= mosi_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
        end
    end

    always_comb begin
        active_d = active_q;
        div_d    = div_q;
        halves_d = halves_q;
        sck_d    = sck_q;
        mosi_d   = mosi_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        if (load) begin
            active_d = 1'b1;
            div_d    = DIV_W'(CLK_DIV - 1);
            halves_d = HALF_W'(2 * FRAME_W);
            sck_d    = 1'b0;
            mosi_d   = cmd[FRAME_W-1];
            tx_d     = {cmd[FRAME_W-2:0], 1'b0};
        end else if (active_q) begin
            if (div_q != '0) begin
                div_d = div_q - DIV_W'(1);
            end else if (halves_q == '0) begin
                active_d = 1'b0;
                mosi_d   = 1'b0;
            end else begin
                halves_d = halves_q - HALF_W'(1);
                div_d    = DIV_W'(CLK_DIV - 1);
                if (!sck_q) begin
                    sck_d = 1'b1;
                    rx_d  = {rx_q[FRAME_W-2:0], miso};
                end else begin
                    sck_d  = 1'b0;
                    mosi_d = tx_q[FRAME_W-1];
                    tx_d   = {tx_q[FRAME_W-2:0], 1'b0};
                end
            end
        end
    end

    assign frame_done = active_q && (div_q == '0) && (halves_q == '0);
    assign sck        = sck_q;
    assign mosi       = mosi_q;
    assign rx_word    = rx_q;

endmodule

// File: rtl/spi_daq_scan_ctrl.sv
// SPI DAQ scan sequencer: walks the latched channel mask in ascending order,
// runs one SPI mode-0 frame per enabled channel and returns each captured
// word on a valid/ready stream.
//   clk, rst_n            : clock, async active-low reset
//   start, chan_mask      : begin a scan; mask latched when start is accepted
//   busy, done            : scan in progress / one-cycle end-of-scan pulse
//   res_valid/ready/ch/data : result stream
//   sck, cs_n, mosi, miso : SPI bus
// Optional build macro SPI_DAQ_SCAN_CONT_EN adds input cont: when high at
// the last result of a scan, the scan restarts from channel 0 after done.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for start
// SELECT    | find lowest enabled channel at/above pointer, load command
// SETUP     | cs_n low, sck low, command MSB on mosi (CLK_DIV cycles)
// SHIFT     | FRAME_W sck periods driven by the shifter
// GAP       | cs_n high for CS_GAP cycles
// RESULT    | present result, wait for handshake
// FINISH    | done pulse, return to IDLE (or SELECT when continuing)
module spi_daq_scan_ctrl
    import spi_daq_pkg::*;
#(
    parameter int  NUM_CH  = 4,
    parameter int  FRAME_W = 16,
    parameter int  CLK_DIV = 2,
    parameter int  CS_GAP  = 2,
    localparam int CH_W    = $clog2(NUM_CH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [NUM_CH-1:0]  chan_mask,
`ifdef SPI_DAQ_SCAN_CONT_EN
    input  logic               cont,
`endif
    output logic               busy,
    output logic               done,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [CH_W-1:0]    res_ch,
    output logic [FRAME_W-1:0] res_data,
    output logic               sck,
    output logic               cs_n,
    output logic               mosi,
    input  logic               miso
);

    // Pointer is one bit wider than a channel so it can sit past the last channel.
    localparam int PTR_W   = CH_W + 1;
    localparam int TMR_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    spi_scan_state_e    state_q, state_d;
    logic [NUM_CH-1:0]  mask_q, mask_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               res_valid_q, res_valid_d;
    logic [CH_W-1:0]    res_ch_q, res_ch_d;
    logic [FRAME_W-1:0] res_data_q, res_data_d;
    logic               cs_n_q, cs_n_d;
`ifdef SPI_DAQ_SCAN_CONT_EN
    logic               cont_q, cont_d;
`endif

    logic               sel_found;
    logic [CH_W-1:0]    sel_ch;
    logic [FRAME_W-1:0] cmd;
    logic               load;
    logic               frame_done;
    logic [FRAME_W-1:0] rx_word;

    always_comb begin
        sel_found = 1'b0;
        sel_ch    = '0;
        // Descending walk so the lowest qualifying channel is the one kept.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_q[i] && (PTR_W'(i) >= ptr_q)) begin
                sel_found = 1'b1;
                sel_ch    = CH_W'(i);
            end
        end
    end

    assign cmd = FRAME_W'(build_cmd(4'(sel_ch), FRAME_W, CH_W));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_SELECT;
            ST_SELECT: state_d = sel_found ? ST_SETUP : ST_FINISH;
            ST_SETUP:  if (tmr_q == '0) state_d = ST_SHIFT;
            ST_SHIFT:  if (frame_done) state_d = ST_GAP;
            ST_GAP:    if (tmr_q == '0) state_d = ST_RESULT;
            ST_RESULT: if (res_valid_q && res_ready) state_d = ST_SELECT;
`ifdef SPI_DAQ_SCAN_CONT_EN
            ST_FINISH: state_d = cont_q ? ST_SELECT : ST_IDLE;
`else
            ST_FINISH: state_d = ST_IDLE;
`endif
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        mask_d      = mask_q;
        ptr_d       = ptr_q;
        ch_d        = ch_q;
        tmr_d       = tmr_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        res_valid_d = res_valid_q;
        res_ch_d    = res_ch_q;
        res_data_d  = res_data_q;
        cs_n_d      = cs_n_q;
        load        = 1'b0;
`ifdef SPI_DAQ_SCAN_CONT_EN
        cont_d      = cont_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mask_d = chan_mask;
                    ptr_d  = '0;
                    busy_d = 1'b1;
`ifdef SPI_DAQ_SCAN_CONT_EN
                    cont_d = 1'b0;
`endif
                end
            end
            ST_SELECT: begin
                if (sel_found) begin
                    ch_d   = sel_ch;
                    load   = 1'b1;
                    cs_n_d = 1'b0;
                    tmr_d  = TMR_W'(CLK_DIV - 1);
                end else begin
                    done_d = 1'b1;
                end
            end
            ST_SETUP: begin
                if (tmr_q != '0) tmr_d = tmr_q - TMR_W'(1);
            end
            ST_SHIFT: begin
                if (frame_done) begin
                    cs_n_d = 1'b1;
                    tmr_d  = TMR_W'(CS_GAP - 1);
                end
            end
            ST_GAP: begin
                if (tmr_q != '0) tmr_d = tmr_q - TMR_W'(1);
            end
            ST_RESULT: begin
                // First RESULT cycle publishes the word; it then holds until accepted.
                if (!res_valid_q) begin
                    res_valid_d = 1'b1;
                    res_ch_d    = ch_q;
                    res_data_d  = rx_word;
                end else if (res_ready) begin
                    res_valid_d = 1'b0;
                    ptr_d       = PTR_W'(ch_q) + PTR_W'(1);
`ifdef SPI_DAQ_SCAN_CONT_EN
                    cont_d      = cont;
`endif
                end
            end
            ST_FINISH: begin
`ifdef SPI_DAQ_SCAN_CONT_EN
                if (cont_q) begin
                    ptr_d = '0;
                end else begin
                    busy_d = 1'b0;
                end
`else
                busy_d = 1'b0;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q      <= '0;
            ptr_q       <= '0;
            ch_q        <= '0;
            tmr_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_ch_q    <= '0;
            res_data_q  <= '0;
            cs_n_q      <= 1'b1;
`ifdef SPI_DAQ_SCAN_CONT_EN
            cont_q      <= 1'b0;
`endif
        end else begin
            mask_q      <= mask_d;
            ptr_q       <= ptr_d;
            ch_q        <= ch_d;
            tmr_q       <= tmr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            res_valid_q <= res_valid_d;
            res_ch_q    <= res_ch_d;
            res_data_q  <= res_data_d;
            cs_n_q      <= cs_n_d;
`ifdef SPI_DAQ_SCAN_CONT_EN
            cont_q      <= cont_d;
`endif
        end
    end

    spi_daq_shifter #(
        .FRAME_W (FRAME_W),
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .cmd        (cmd),
        .miso       (miso),
        .sck        (sck),
        .mosi       (mosi),
        .frame_done (frame_done),
        .rx_word    (rx_word)
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign res_valid = res_valid_q;
    assign res_ch    = res_ch_q;
    assign res_data  = res_data_q;
    assign cs_n      = cs_n_q;

endmodule

// File: tb/tb_spi_daq_scan_ctrl.sv
module tb_spi_daq_scan_ctrl;

    localparam int NUM_CH  = 4;
    localparam int FRAME_W = 16;
    localparam int CLK_DIV = 2;
    localparam int CS_GAP  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  chan_mask = 4'b0000;
    logic        res_ready = 1'b0;
    logic        miso = 1'b0;
`ifdef SPI_DAQ_SCAN_CONT_EN
    logic        cont = 1'b0;
`endif
    logic        busy, done, res_valid, sck, cs_n, mosi;
    logic [1:0]  res_ch;
    logic [15:0] res_data;

    spi_daq_scan_ctrl #(
        .NUM_CH  (NUM_CH),
        .FRAME_W (FRAME_W),
        .CLK_DIV (CLK_DIV),
        .CS_GAP  (CS_GAP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .chan_mask (chan_mask),
`ifdef SPI_DAQ_SCAN_CONT_EN
        .cont      (cont),
`endif
        .busy      (busy),
        .done      (done),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_ch    (res_ch),
        .res_data  (res_data),
        .sck       (sck),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .miso      (miso)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Slave model and bus monitor (evaluated on the falling clock edge)
    logic [15:0] sw [64];
    logic [15:0] mosi_log [64];
    logic [1:0]  rch_log [64];
    logic [15:0] rdat_log [64];
    int cyc = 0, nframes = 0, cur_frame = 0, low_cnt = 0, rise_cnt = 0, miso_idx = 0;
    int last_low = 0, last_rises = 0, nres = 0, ndone = 0, ncs_low = 0;
    int t_cs_rise = 0, t_cs_fall = 0, t_valid_rise = 0, t_hs = 0;
    logic [15:0] mosi_w = '0;
    logic prev_cs = 1'b1, prev_sck = 1'b0, prev_valid = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!cs_n) ncs_low++;
        if (!cs_n && prev_cs) begin
            cur_frame = nframes;
            nframes++;
            low_cnt = 0; rise_cnt = 0; miso_idx = 0; mosi_w = '0;
            t_cs_fall = cyc;
        end
        if (cs_n && !prev_cs) begin
            last_low = low_cnt;
            last_rises = rise_cnt;
            mosi_log[cur_frame % 64] = mosi_w;
            t_cs_rise = cyc;
        end
        if (!cs_n) begin
            low_cnt++;
            if (sck && !prev_sck) begin
                rise_cnt++;
                mosi_w = {mosi_w[14:0], mosi};
            end
            if (!sck && prev_sck) miso_idx++;
        end
        miso = (!cs_n && miso_idx < 16) ? sw[cur_frame % 64][15 - miso_idx] : 1'b0;
        if (res_valid && !prev_valid) t_valid_rise = cyc;
        if (res_valid && res_ready) begin
            rch_log[nres % 64] = res_ch;
            rdat_log[nres % 64] = res_data;
            nres++;
            t_hs = cyc;
        end
        if (done) ndone++;
        prev_cs = cs_n;
        prev_sck = sck;
        prev_valid = res_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // which: 0 = done, 1 = res_valid, 2 = cs_n low
    task automatic wait_for(input int which, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < max_cyc; k++) begin
            tick();
            if ((which == 0 && done) || (which == 1 && res_valid) || (which == 2 && !cs_n)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int n0, d0, f0, cs0, bad;
        bit ok;
        logic [1:0]  cap_ch;
        logic [15:0] cap_dat;

        for (int i = 0; i < 64; i++) sw[i] = 16'h0000;

        // Reset values
        #2 rst_n = 1'b0;
        tick(3);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_ch", res_ch, 0);
        check("rst_res_data", res_data, 0);
        check("rst_sck", sck, 0);
        check("rst_cs_n", cs_n, 1);
        check("rst_mosi", mosi, 0);
        rst_n = 1'b1;
        tick(2);

        // 1: mask 0101, ready always high
        n0 = nres; d0 = ndone; f0 = nframes;
        sw[f0 % 64] = 16'hA5C3;
        sw[(f0 + 1) % 64] = 16'h0F0F;
        chan_mask = 4'b0101;
        res_ready = 1'b1;
        pulse_start();
        check("t1_busy_after_start", busy, 1);
        wait_for(0, 600, ok);
        check("t1_done_seen", ok, 1);
        check("t1_busy_at_done", busy, 1);
        tick();
        check("t1_busy_after_done", busy, 0);
        check("t1_num_results", nres - n0, 2);
        check("t1_res0_ch", rch_log[n0 % 64], 0);
        check("t1_res0_data", rdat_log[n0 % 64], 16'hA5C3);
        check("t1_res1_ch", rch_log[(n0 + 1) % 64], 2);
        check("t1_res1_data", rdat_log[(n0 + 1) % 64], 16'h0F0F);
        check("t1_mosi0", mosi_log[f0 % 64], 16'h8000);
        check("t1_mosi1", mosi_log[(f0 + 1) % 64], 16'hC000);
        check("t1_cs_low_cycles", last_low, 66);
        check("t1_sck_rises", last_rises, 16);
        check("t1_done_count", ndone - d0, 1);

        // 2: same scan with back-pressure on the first result
        n0 = nres; f0 = nframes;
        sw[f0 % 64] = 16'hA5C3;
        sw[(f0 + 1) % 64] = 16'h0F0F;
        res_ready = 1'b0;
        pulse_start();
        wait_for(1, 300, ok);
        check("t2_valid_seen", ok, 1);
        cap_ch = res_ch;
        cap_dat = res_data;
        check("t2_res0_ch", cap_ch, 0);
        check("t2_res0_data", cap_dat, 16'hA5C3);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (!(res_valid === 1'b1 && res_ch === cap_ch && res_data === cap_dat && cs_n === 1'b1)) bad++;
        end
        check("t2_hold_stable", bad, 0);
        check("t2_valid_after_cs_rise", t_valid_rise - t_cs_rise, CS_GAP + 1);
        res_ready = 1'b1;
        tick(4);
        check("t2_next_cs_fall", t_cs_fall - t_hs, 2);
        wait_for(0, 300, ok);
        check("t2_done_seen", ok, 1);
        tick();
        check("t2_num_results", nres - n0, 2);
        check("t2_res1_ch", rch_log[(n0 + 1) % 64], 2);
        check("t2_res1_data", rdat_log[(n0 + 1) % 64], 16'h0F0F);

        // 3: empty mask
        cs0 = ncs_low; d0 = ndone;
        chan_mask = 4'b0000;
        pulse_start();
        check("t3_c1_busy", busy, 1);
        check("t3_c1_done", done, 0);
        tick();
        check("t3_c2_done", done, 1);
        check("t3_c2_busy", busy, 1);
        tick();
        check("t3_c3_done", done, 0);
        check("t3_c3_busy", busy, 0);
        tick();
        check("t3_no_cs_low", ncs_low - cs0, 0);
        check("t3_done_count", ndone - d0, 1);

        // 4: reset in the middle of a frame
        n0 = nres; f0 = nframes;
        sw[f0 % 64] = 16'hFFFF;
        chan_mask = 4'b0001;
        res_ready = 1'b1;
        pulse_start();
        wait_for(2, 20, ok);
        check("t4_cs_fell", ok, 1);
        tick(30);
        check("t4_pre_cs_n", cs_n, 0);
        check("t4_pre_sck", sck, 1);
        #3 rst_n = 1'b0;
        #1;
        check("t4_async_cs_n", cs_n, 1);
        check("t4_async_sck", sck, 0);
        check("t4_async_busy", busy, 0);
        tick(2);
        rst_n = 1'b1;
        cs0 = ncs_low;
        tick(150);
        check("t4_no_result", nres - n0, 0);
        check("t4_res_valid", res_valid, 0);
        check("t4_busy", busy, 0);
        check("t4_no_new_frame", ncs_low - cs0, 0);

        // 5: single channel 3, stray starts and mask changes while busy
        n0 = nres; d0 = ndone; f0 = nframes;
        sw[f0 % 64] = 16'h1234;
        chan_mask = 4'b1000;
        pulse_start();
        chan_mask = 4'b1111;
        tick(5);
        pulse_start();
        tick(40);
        pulse_start();
        wait_for(0, 300, ok);
        check("t5_done_seen", ok, 1);
        tick();
        check("t5_num_results", nres - n0, 1);
        check("t5_res_ch", rch_log[n0 % 64], 3);
        check("t5_res_data", rdat_log[n0 % 64], 16'h1234);
        check("t5_mosi", mosi_log[f0 % 64], 16'hE000);
        check("t5_cs_low_cycles", last_low, 66);
        check("t5_sck_rises", last_rises, 16);
        check("t5_done_count", ndone - d0, 1);
        tick(150);
        check("t5_no_extra_results", nres - n0, 1);
        check("t5_idle_busy", busy, 0);

`ifdef SPI_DAQ_SCAN_CONT_EN
        // 6: continuous scanning of channels 0 and 1
        n0 = nres; d0 = ndone; f0 = nframes;
        for (int k = 0; k < 6; k++) sw[(f0 + k) % 64] = 16'h3C00 + 16'(k);
        chan_mask = 4'b0011;
        res_ready = 1'b1;
        cont = 1'b1;
        pulse_start();
        wait_for(0, 400, ok);
        check("t6_done1_seen", ok, 1);
        check("t6_busy_at_done1", busy, 1);
        tick();
        check("t6_busy_after_done1", busy, 1);
        wait_for(0, 400, ok);
        check("t6_done2_seen", ok, 1);
        cont = 1'b0;
        tick();
        wait_for(0, 400, ok);
        check("t6_done3_seen", ok, 1);
        tick();
        check("t6_busy_stopped", busy, 0);
        check("t6_done_count", ndone - d0, 3);
        check("t6_num_results", nres - n0, 6);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("t6_res%0d_ch", k), rch_log[(n0 + k) % 64], k % 2);
            check($sformatf("t6_res%0d_data", k), rdat_log[(n0 + k) % 64], 16'h3C00 + k);
        end
        check("t6_mosi_ch1", mosi_log[(f0 + 1) % 64], 16'hA000);
        tick(100);
        check("t6_no_more_results", nres - n0, 6);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
